wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the two writeback ports (register file write / ROB completion) between up to four functional units in the dual-issue core. Each cycle it grants at most two requesting FUs, using round-robin priority with a per-requester starvation override, and registers the winners onto the writeback ports with one-cycle latency. Flush and downstream stall are honoured without losing or duplicating results.

## Interface
- N_REQ, 4, number of requesting functional units (2..8)
- N_PORTS, 2, writeback ports (fixed at 2)
- DATA_W, 32, result width
- PREG_W, 6, physical destination register index width
- TICKET_W, 3, ROB ticket width
- STARVE_LIM, 8, consecutive lost cycles before a requester becomes urgent (1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  pipeline flush; synchronous
- wb_stall_i  in  1  downstream cannot accept writeback this cycle
- req_valid_i  in  N_REQ  FU has a result pending
- req_ready_o  out  N_REQ  grant; combinational, same cycle as req_valid_i
- req_pdst_i  in  N_REQ×PREG_W  destination preg per FU
- req_data_i  in  N_REQ×DATA_W  result per FU
- req_ticket_i  in  N_REQ×TICKET_W  ROB ticket per FU
- wb_valid_o  out  N_PORTS  port carries a result (registered)
- wb_pdst_o  out  N_PORTS×PREG_W  registered pdst
- wb_data_o  out  N_PORTS×DATA_W  registered data
- wb_ticket_o  out  N_PORTS×TICKET_W  registered ticket
- wb_src_o  out  N_PORTS×clog2(N_REQ)  index of the granted FU (debug/perf)

## Operation
- Handshake: a transfer occurs when req_valid_i[i] && req_ready_o[i]. The requester holds valid and its payload stable until granted. req_ready_o[i] is never high without req_valid_i[i].
- At most N_PORTS grants per cycle, with no requester granted twice.
- Grant eligibility: no grants while flush_i or wb_stall_i is high.
- Urgent set: requesters with valid and starve_cnt[i] ≥ STARVE_LIM.
- Selection order:
  - Urgent requesters are granted first, lowest index first.
  - Remaining ports are filled by scanning non-urgent valid requesters from rr_ptr upward, with modulo N_REQ wrap.
- Port assignment: first selected goes to port 0, second to port 1. A single grant always uses port 0.
- rr_ptr update: after any grant cycle, becomes (index of last granted via round-robin scan + 1) mod N_REQ. Unchanged if no round-robin grant occurred. Urgent grants do not move it.
- Starvation counters:
  - starve_cnt[i] += 1, saturating at STARVE_LIM, when valid, not granted, and neither flush nor stall is high.
  - Cleared on grant.
  - Cleared when valid is low.
  - All cleared on flush_i.
  - Held during wb_stall_i.
- Output registers: wb_valid_o[p] <= granted on port p. Payload fields load only when granted; they are don't-care otherwise.
- Flush: outputs registered in the flush cycle get wb_valid_o = 0. Results already on the ports during the flush cycle are not retracted.

## Timing
- Reset: wb_valid_o = 0, wb_pdst_o/wb_data_o/wb_ticket_o/wb_src_o = 0, rr_ptr = 0, all starve_cnt = 0, req_ready_o = 0 (combinational, follows reset state).
- Latency: grant in cycle T, result on wb_*_o in T+1, for exactly one cycle.
- Throughput: 2 results/cycle sustained.
- wb_stall_i high in T: no grants in T, and wb_valid_o = 0 in T+1. A stall does not hold outputs; downstream must sample before raising stall.
- Simultaneous flush_i and wb_stall_i: flush semantics apply (counters cleared).
- rst_n asserted mid-operation: all state is cleared immediately. Pending FU results are dropped; FUs are reset by the same rst_n.

## Test plan
- Single requester: req_valid_i = 4'b0100, pdst 5, data 0xDEADBEEF, ticket 3 → ready[2] = 1 same cycle; next cycle wb_valid_o = 2'b01, port 0 shows pdst 5 / data 0xDEADBEEF / ticket 3 / src 2.
- Full contention: all four valid continuously, rr_ptr = 0 → grants {0,1}, then {2,3}, then {0,1}. Each FU wins every 2 cycles, and both ports are valid every cycle.
- Starvation override with N_REQ = 4, STARVE_LIM = 2:
  - Setup: FU3 valid continuously; FU0, FU1 and FU2 re-raise valid every cycle; rr_ptr held so that FU3 loses twice.
  - Expect: on the third cycle FU3 gets port 0 as urgent, its counter clears, and rr_ptr is unchanged by that urgent grant.
- Stall: all valid, wb_stall_i high for 3 cycles → req_ready_o = 0, wb_valid_o = 0 from the next cycle, starvation counters frozen. After release, grants resume from the pre-stall rr_ptr.
- Flush: grant FU1 in T with flush_i high in T → wb_valid_o = 0 in T+1 and all counters are 0. A result granted in T-1 still appears in T.
- Async reset mid-traffic: drop rst_n between clock edges → wb_valid_o = 0 immediately, and the first grant after release starts from index 0.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// FU request side and writeback port side of wb_port_arbiter.
// master = FUs plus downstream consumer, slave = the arbiter.
interface wb_port_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int N_PORTS  = 2,
  parameter int DATA_W   = 32,
  parameter int PREG_W   = 6,
  parameter int TICKET_W = 3
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]                 req_valid_i;
  logic [N_REQ-1:0]                 req_ready_o;
  logic [N_REQ-1:0][PREG_W-1:0]     req_pdst_i;
  logic [N_REQ-1:0][DATA_W-1:0]     req_data_i;
  logic [N_REQ-1:0][TICKET_W-1:0]   req_ticket_i;

  logic [N_PORTS-1:0]               wb_valid_o;
  logic [N_PORTS-1:0][PREG_W-1:0]   wb_pdst_o;
  logic [N_PORTS-1:0][DATA_W-1:0]   wb_data_o;
  logic [N_PORTS-1:0][TICKET_W-1:0] wb_ticket_o;
  logic [N_PORTS-1:0][SRC_W-1:0]    wb_src_o;

  modport master (
    output req_valid_i, req_pdst_i, req_data_i, req_ticket_i,
    input  req_ready_o, wb_valid_o, wb_pdst_o, wb_data_o, wb_ticket_o, wb_src_o
  );

  modport slave (
    input  req_valid_i, req_pdst_i, req_data_i, req_ticket_i,
    output req_ready_o, wb_valid_o, wb_pdst_o, wb_data_o, wb_ticket_o, wb_src_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Grants up to N_PORTS FU results per cycle (starved requesters first, then round-robin)
// onto registered writeback ports; one-cycle latency, no grants during flush_i or wb_stall_i.
module wb_port_arbiter #(
  parameter int N_REQ      = 4,
  parameter int N_PORTS    = 2,
  parameter int DATA_W     = 32,
  parameter int PREG_W     = 6,
  parameter int TICKET_W   = 3,
  parameter int STARVE_LIM = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            wb_stall_i,
  wb_port_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(N_REQ);
  localparam int CNT_W = 8;

  logic [SRC_W-1:0]                 r_rr_ptr;
  logic [N_REQ-1:0][CNT_W-1:0]      r_cnt;
  logic [N_PORTS-1:0]               r_wb_vld;
  logic [N_PORTS-1:0][PREG_W-1:0]   r_wb_pdst;
  logic [N_PORTS-1:0][DATA_W-1:0]   r_wb_data;
  logic [N_PORTS-1:0][TICKET_W-1:0] r_wb_ticket;
  logic [N_PORTS-1:0][SRC_W-1:0]    r_wb_src;

  logic                             w_elig;
  logic [N_REQ-1:0]                 w_urgent;
  logic [N_REQ-1:0]                 w_grant;
  logic [N_PORTS-1:0]               w_sel_vld;
  logic [N_PORTS-1:0][SRC_W-1:0]    w_sel_idx;
  logic                             w_rr_hit;
  logic [SRC_W-1:0]                 w_rr_last;
  logic [SRC_W:0]                   w_sum;
  logic [SRC_W-1:0]                 w_idx;
  int                               w_nsel;

  // Gating on rst_n keeps ready low while the async reset is held.
  assign w_elig = rst_n && !flush_i && !wb_stall_i;

  always_comb begin
    w_urgent = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_urgent[i] = bus.req_valid_i[i] && (r_cnt[i] >= CNT_W'(STARVE_LIM));
    end
  end

  always_comb begin
    w_grant   = '0;
    w_sel_vld = '0;
    w_sel_idx = '0;
    w_rr_hit  = 1'b0;
    w_rr_last = r_rr_ptr;
    w_sum     = '0;
    w_idx     = '0;
    w_nsel    = 0;
    if (w_elig) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_urgent[i] && w_nsel < N_PORTS) begin
          w_grant[i] = 1'b1;
          for (int p = 0; p < N_PORTS; p++) begin
            if (p == w_nsel) begin
              w_sel_vld[p] = 1'b1;
              w_sel_idx[p] = SRC_W'(i);
            end
          end
          w_nsel = w_nsel + 1;
        end
      end
      // Round-robin fill of the remaining ports, wrapping modulo N_REQ.
      for (int k = 0; k < N_REQ; k++) begin
        w_sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
        if (w_sum >= (SRC_W+1)'(N_REQ)) begin
          w_sum = w_sum - (SRC_W+1)'(N_REQ);
        end
        w_idx = w_sum[SRC_W-1:0];
        if (bus.req_valid_i[w_idx] && !w_urgent[w_idx] && w_nsel < N_PORTS) begin
          w_grant[w_idx] = 1'b1;
          for (int p = 0; p < N_PORTS; p++) begin
            if (p == w_nsel) begin
              w_sel_vld[p] = 1'b1;
              w_sel_idx[p] = w_idx;
            end
          end
          w_nsel    = w_nsel + 1;
          w_rr_hit  = 1'b1;
          w_rr_last = w_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_wb_vld    <= '0;
      r_wb_pdst   <= '0;
      r_wb_data   <= '0;
      r_wb_ticket <= '0;
      r_wb_src    <= '0;
    end else begin
      if (w_rr_hit) begin
        r_rr_ptr <= (w_rr_last == SRC_W'(N_REQ-1)) ? '0 : SRC_W'(w_rr_last + 1'b1);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (flush_i) begin
          r_cnt[i] <= '0;
        end else if (!wb_stall_i) begin
          if (!bus.req_valid_i[i] || w_grant[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] < CNT_W'(STARVE_LIM)) begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end
      end
      for (int p = 0; p < N_PORTS; p++) begin
        r_wb_vld[p] <= w_sel_vld[p];
        if (w_sel_vld[p]) begin
          r_wb_pdst[p]   <= bus.req_pdst_i[w_sel_idx[p]];
          r_wb_data[p]   <= bus.req_data_i[w_sel_idx[p]];
          r_wb_ticket[p] <= bus.req_ticket_i[w_sel_idx[p]];
          r_wb_src[p]    <= w_sel_idx[p];
        end
      end
    end
  end

  assign bus.req_ready_o = w_grant;
  assign bus.wb_valid_o  = r_wb_vld;
  assign bus.wb_pdst_o   = r_wb_pdst;
  assign bus.wb_data_o   = r_wb_data;
  assign bus.wb_ticket_o = r_wb_ticket;
  assign bus.wb_src_o    = r_wb_src;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed phases plus random traffic against a queue-based model.
module tb_wb_port_arbiter;
  localparam int N   = 5;
  localparam int DW  = 32;
  localparam int PW  = 6;
  localparam int TW  = 3;
  localparam int LIM = 2;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic flush_i    = 1'b0;
  logic wb_stall_i = 1'b0;

  wb_port_arbiter_if #(.N_REQ(N), .N_PORTS(2), .DATA_W(DW), .PREG_W(PW), .TICKET_W(TW)) bus ();

  wb_port_arbiter #(
    .N_REQ(N), .N_PORTS(2), .DATA_W(DW), .PREG_W(PW), .TICKET_W(TW), .STARVE_LIM(LIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .wb_stall_i (wb_stall_i),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // FU-side state: a pending result holds its payload until granted.
  bit            pend   [N];
  logic [PW-1:0] p_pdst [N];
  logic [DW-1:0] p_data [N];
  logic [TW-1:0] p_tkt  [N];
  bit            refill = 1'b0;
  int            pct    = 0;

  // Reference model state.
  int            m_rr;
  int            m_cnt  [N];
  bit            e_vld  [2];
  logic [PW-1:0] e_pdst [2];
  logic [DW-1:0] e_data [2];
  logic [TW-1:0] e_tkt  [2];
  int            e_src  [2];
  int            g_q[$];
  bit            g_rr_hit;
  int            g_rr_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit granted(input int i);
    foreach (g_q[j]) if (g_q[j] == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_rr = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      pend[i]  = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      e_vld[p] = 1'b0; e_pdst[p] = '0; e_data[p] = '0; e_tkt[p] = '0; e_src[p] = 0;
    end
  endtask

  task automatic model_grant();
    g_q.delete();
    g_rr_hit = 1'b0;
    if (!flush_i && !wb_stall_i) begin
      for (int i = 0; i < N; i++)
        if (pend[i] && m_cnt[i] >= LIM && g_q.size() < 2) g_q.push_back(i);
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (pend[idx] && m_cnt[idx] < LIM && g_q.size() < 2) begin
          g_q.push_back(idx);
          g_rr_hit  = 1'b1;
          g_rr_last = idx;
        end
      end
    end
  endtask

  task automatic model_commit();
    for (int p = 0; p < 2; p++) begin
      e_vld[p] = (p < g_q.size());
      if (e_vld[p]) begin
        e_pdst[p] = p_pdst[g_q[p]];
        e_data[p] = p_data[g_q[p]];
        e_tkt[p]  = p_tkt[g_q[p]];
        e_src[p]  = g_q[p];
      end
    end
    if (g_rr_hit) m_rr = (g_rr_last + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (flush_i) m_cnt[i] = 0;
      else if (!wb_stall_i) begin
        if (!pend[i] || granted(i)) m_cnt[i] = 0;
        else if (m_cnt[i] < LIM)   m_cnt[i] = m_cnt[i] + 1;
      end
    end
    foreach (g_q[j]) pend[g_q[j]] = 1'b0;
  endtask

  task automatic new_reqs();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (refill || $urandom_range(99) < pct)) begin
        pend[i]   = 1'b1;
        p_pdst[i] = PW'($urandom);
        p_data[i] = $urandom;
        p_tkt[i]  = TW'($urandom);
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid_i[i]  = pend[i];
      bus.req_pdst_i[i]   = p_pdst[i];
      bus.req_data_i[i]   = p_data[i];
      bus.req_ticket_i[i] = p_tkt[i];
    end
  endtask

  // One cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic step();
    logic [N-1:0] mask;
    drive();
    #1;
    model_grant();
    mask = '0;
    foreach (g_q[j]) mask[g_q[j]] = 1'b1;
    chk("ready", 64'(bus.req_ready_o), 64'(mask));
    chk("wb_valid", 64'(bus.wb_valid_o), 64'({e_vld[1], e_vld[0]}));
    for (int p = 0; p < 2; p++) begin
      if (e_vld[p]) begin
        chk($sformatf("wb_pdst%0d", p),   64'(bus.wb_pdst_o[p]),   64'(e_pdst[p]));
        chk($sformatf("wb_data%0d", p),   64'(bus.wb_data_o[p]),   64'(e_data[p]));
        chk($sformatf("wb_ticket%0d", p), 64'(bus.wb_ticket_o[p]), 64'(e_tkt[p]));
        chk($sformatf("wb_src%0d", p),    64'(bus.wb_src_o[p]),    64'(e_src[p]));
      end
    end
    @(posedge clk);
    model_commit();
    @(negedge clk);
    new_reqs();
  endtask

  initial begin
    model_reset();
    refill = 1'b1;
    new_reqs();
    drive();
    #12;
    chk("rst_ready",  64'(bus.req_ready_o), 64'd0);
    chk("rst_valid",  64'(bus.wb_valid_o),  64'd0);
    chk("rst_pdst",   64'(bus.wb_pdst_o),   64'd0);
    chk("rst_data",   64'(bus.wb_data_o),   64'd0);
    chk("rst_ticket", 64'(bus.wb_ticket_o), 64'd0);
    chk("rst_src",    64'(bus.wb_src_o),    64'd0);
    model_reset();
    refill = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester on FU2.
    pend[2] = 1'b1; p_pdst[2] = 6'd5; p_data[2] = 32'hDEADBEEF; p_tkt[2] = 3'd3;
    step();
    chk("single_valid", 64'(bus.wb_valid_o),     64'd1);
    chk("single_src",   64'(bus.wb_src_o[0]),    64'd2);
    chk("single_data",  64'(bus.wb_data_o[0]),   64'hDEADBEEF);
    chk("single_pdst",  64'(bus.wb_pdst_o[0]),   64'd5);
    step();
    step();

    // Full contention: every FU re-raises as soon as it is granted.
    refill = 1'b1;
    new_reqs();
    repeat (10) step();

    wb_stall_i = 1'b1;
    repeat (3) step();
    wb_stall_i = 1'b0;
    repeat (4) step();

    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (4) step();

    // Async reset dropped between clock edges.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.wb_valid_o),  64'd0);
    chk("arst_ready", 64'(bus.req_ready_o), 64'd0);
    model_reset();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    new_reqs();
    repeat (6) step();

    refill = 1'b0;
    pct    = 40;
    repeat (3000) begin
      flush_i    = ($urandom_range(49) == 0);
      wb_stall_i = ($urandom_range(7) == 0);
      step();
    end
    flush_i    = 1'b0;
    wb_stall_i = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
